// File: rtl/bbox_list_store.sv
// Double-buffered bounding-box list: one bank fills from the labeler while the
// other is frozen and read by the crossing-box merger.
module bbox_list_store #(
    parameter int DEPTH     = 512,
    parameter int ADDR_W    = 9,
    parameter int MAX_BOXES = 511
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              wr_en,
    input  logic [6:0]        wr_x0,
    input  logic [6:0]        wr_xn,
    input  logic [5:0]        wr_y0,
    input  logic [5:0]        wr_yn,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [6:0]        rd_x0,
    output logic [6:0]        rd_xn,
    output logic [5:0]        rd_y0,
    output logic [5:0]        rd_yn,
    output logic [8:0]        box_size,
    output logic [DEPTH-1:0]  box_flag_true,
    output logic              start,
    input  logic              cross_complete,
    output logic              busy,
    output logic              overflow,
    output logic              frame_drop,
    output logic              empty_frame
);
    localparam int SIZE_W = 9;
    localparam int REC_W  = 26;

    typedef enum logic [1:0] {IDLE, FILL, PEND} state_t;
    state_t state_reg, state_next;

    logic [SIZE_W-1:0] wr_cnt_reg, wr_cnt_next, cnt_base, final_cnt;
    logic [SIZE_W-1:0] box_size_reg;
    logic [DEPTH-1:0]  flags_reg, flags_next;
    logic wb_reg, rb_reg, busy_reg, start_reg, start_pend_reg, cc_prev_reg;
    logic overflow_reg, frame_drop_reg, empty_frame_reg, rd_hit_reg;
    logic cc_rise, merger_idle, swap, wr_accept, wr_drop, open_frame, drop_req;
    logic [REC_W-1:0] mem [0:2*DEPTH-1];
    logic [REC_W-1:0] rd_data_reg;

    // Completion is an edge; a level still high from an earlier frame is ignored.
    assign cc_rise     = cross_complete & ~cc_prev_reg & busy_reg & ~start_reg;
    assign merger_idle = ~busy_reg | cc_rise;

    always_comb begin
        cnt_base   = (state_reg == FILL && frame_start) ? '0 : wr_cnt_reg;
        wr_accept  = (state_reg == FILL) && wr_en && (cnt_base != SIZE_W'(MAX_BOXES));
        wr_drop    = (state_reg == FILL) && wr_en && (cnt_base == SIZE_W'(MAX_BOXES));
        final_cnt  = cnt_base + SIZE_W'(wr_accept);
        swap       = ((state_reg == FILL) && frame_end && merger_idle) ||
                     ((state_reg == PEND) && cc_rise);
        open_frame = frame_start && (state_reg == IDLE || state_reg == FILL);
        drop_req   = frame_start && (state_reg == PEND);
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
            assign flags_next[gi] = (32'(gi) < 32'(final_cnt));
        end
    endgenerate

    // Write-side FSM
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (frame_start) state_next = FILL;
            FILL:    if (frame_end)   state_next = merger_idle ? IDLE : PEND;
            PEND:    if (cc_rise)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = (state_reg == FILL);
    end

    always_comb begin
        wr_cnt_next = wr_cnt_reg;
        if (state_reg == IDLE && frame_start) wr_cnt_next = '0;
        else if (state_reg == FILL)           wr_cnt_next = final_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_reg      <= '0;
            wb_reg          <= 1'b0;
            rb_reg          <= 1'b1;
            busy_reg        <= 1'b0;
            start_reg       <= 1'b0;
            start_pend_reg  <= 1'b0;
            cc_prev_reg     <= 1'b0;
            overflow_reg    <= 1'b0;
            frame_drop_reg  <= 1'b0;
            empty_frame_reg <= 1'b0;
            box_size_reg    <= '0;
            flags_reg       <= '0;
            rd_hit_reg      <= 1'b0;
        end else begin
            wr_cnt_reg      <= wr_cnt_next;
            cc_prev_reg     <= cross_complete;
            start_reg       <= start_pend_reg;
            start_pend_reg  <= 1'b0;
            frame_drop_reg  <= drop_req;
            empty_frame_reg <= 1'b0;
            rd_hit_reg      <= (32'(rd_addr) < 32'(box_size_reg));
            if (wr_drop)         overflow_reg <= 1'b1;
            else if (open_frame) overflow_reg <= 1'b0;
            if (cc_rise) busy_reg <= 1'b0;
            // Size and flags land one cycle before start so the merger sees them stable.
            if (swap) begin
                wb_reg       <= ~wb_reg;
                rb_reg       <= ~rb_reg;
                box_size_reg <= final_cnt;
                flags_reg    <= flags_next;
                if (final_cnt != '0) begin
                    busy_reg       <= 1'b1;
                    start_pend_reg <= 1'b1;
                end else begin
                    empty_frame_reg <= 1'b1;
                end
            end
        end
    end

    // Both banks share one array; the bank bit is the address MSB.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[{wb_reg, cnt_base[ADDR_W-1:0]}] <= {wr_x0, wr_xn, wr_y0, wr_yn};
        rd_data_reg <= mem[{rb_reg, rd_addr}];
    end

    assign {rd_x0, rd_xn, rd_y0, rd_yn} = rd_hit_reg ? rd_data_reg : '0;
    assign box_size      = box_size_reg;
    assign box_flag_true = flags_reg;
    assign start         = start_reg;
    assign busy          = busy_reg;
    assign overflow      = overflow_reg;
    assign frame_drop    = frame_drop_reg;
    assign empty_frame   = empty_frame_reg;
endmodule

// File: tb/tb_bbox_list_store.sv
// Directed bench for bbox_list_store: frame handoff, PEND/drop, overflow,
// empty frame and reset while busy, with hand-computed expectations.
module tb_bbox_list_store;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;

    logic clk = 1'b0;
    logic reset, frame_start, frame_end, wr_en, cross_complete;
    logic [6:0] wr_x0, wr_xn, rd_x0, rd_xn;
    logic [5:0] wr_y0, wr_yn, rd_y0, rd_yn;
    logic [ADDR_W-1:0] rd_addr;
    logic [8:0] box_size;
    logic [DEPTH-1:0] box_flag_true;
    logic wr_ready, start, busy, overflow, frame_drop, empty_frame;
    logic [DEPTH-1:0] exp_mask;
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bbox_list_store #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_BOXES(511)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
        .wr_en(wr_en), .wr_x0(wr_x0), .wr_xn(wr_xn), .wr_y0(wr_y0), .wr_yn(wr_yn),
        .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_x0(rd_x0), .rd_xn(rd_xn),
        .rd_y0(rd_y0), .rd_yn(rd_yn), .box_size(box_size), .box_flag_true(box_flag_true),
        .start(start), .cross_complete(cross_complete), .busy(busy),
        .overflow(overflow), .frame_drop(frame_drop), .empty_frame(empty_frame)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int x0, input int xn, input int y0, input int yn);
        wr_en = 1'b1;
        wr_x0 = 7'(x0); wr_xn = 7'(xn); wr_y0 = 6'(y0); wr_yn = 6'(yn);
        tick();
        wr_en = 1'b0;
    endtask

    function automatic logic [25:0] pk(input int x0, input int xn, input int y0, input int yn);
        return {7'(x0), 7'(xn), 6'(y0), 6'(yn)};
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_flags"}, {wr_ready, start, busy, overflow, frame_drop, empty_frame}, 0);
        check_eq({tag, "_size"}, box_size, 0);
        check_eq({tag, "_mask"}, box_flag_true, 0);
        check_eq({tag, "_rd"}, {rd_x0, rd_xn, rd_y0, rd_yn}, 0);
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; frame_end = 1'b0; wr_en = 1'b0;
        cross_complete = 1'b0; rd_addr = '0;
        wr_x0 = '0; wr_xn = '0; wr_y0 = '0; wr_yn = '0;
        exp_mask = '0;
        for (int i = 0; i < 511; i++) exp_mask[i] = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_all_zero("reset");

        // Frame 1: junk record, then restart with frame_start+wr_en
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check_eq("f1_wr_ready", wr_ready, 1);
        put(99, 99, 9, 9);
        frame_start = 1'b1; put(2, 5, 1, 4); frame_start = 1'b0;
        put(4, 9, 3, 6);
        put(20, 22, 10, 12);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check_eq("f1_size", box_size, 3);
        check_eq("f1_mask", box_flag_true, 7);
        check_eq("f1_busy", busy, 1);
        check_eq("f1_start_early", start, 0);
        rd_addr = 9'd1; tick();
        check_eq("f1_start", start, 1);
        check_eq("f1_rd1", {rd_x0, rd_xn, rd_y0, rd_yn}, pk(4, 9, 3, 6));
        rd_addr = 9'd0; tick();
        check_eq("f1_start_end", start, 0);
        check_eq("f1_rd0", {rd_x0, rd_xn, rd_y0, rd_yn}, pk(2, 5, 1, 4));
        rd_addr = 9'd3; tick();
        check_eq("f1_rd_oob", {rd_x0, rd_xn, rd_y0, rd_yn}, 0);

        // Frame 2: 5 boxes, last one with frame_end, while frame 1 busy
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        put(1, 2, 3, 4);
        put(5, 6, 7, 8);
        put(10, 11, 12, 13);
        put(30, 40, 20, 30);
        frame_end = 1'b1; put(100, 127, 50, 63); frame_end = 1'b0;
        check_eq("f2_pend_wr_ready", wr_ready, 0);
        check_eq("f2_pend_busy", busy, 1);
        check_eq("f2_pend_size", box_size, 3);
        put(9, 9, 9, 9);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check_eq("f2_drop", frame_drop, 1);
        tick();
        check_eq("f2_drop_end", frame_drop, 0);
        rd_addr = 9'd2; tick();
        check_eq("f2_pend_rd_f1", {rd_x0, rd_xn, rd_y0, rd_yn}, pk(20, 22, 10, 12));
        repeat (8) tick();
        cross_complete = 1'b1; tick();
        check_eq("f2_size", box_size, 5);
        check_eq("f2_mask", box_flag_true, 5'h1f);
        check_eq("f2_busy", busy, 1);
        check_eq("f2_start_early", start, 0);
        tick();
        check_eq("f2_start", start, 1);
        check_eq("f2_idle_after_drop", wr_ready, 0);
        cross_complete = 1'b0;
        rd_addr = 9'd1; tick();
        check_eq("f2_rd1", {rd_x0, rd_xn, rd_y0, rd_yn}, pk(5, 6, 7, 8));
        rd_addr = 9'd4; tick();
        check_eq("f2_rd4", {rd_x0, rd_xn, rd_y0, rd_yn}, pk(100, 127, 50, 63));
        repeat (5) tick();
        cross_complete = 1'b1; tick();
        check_eq("f2_done_busy", busy, 0);
        repeat (3) tick();
        check_eq("f2_hold_busy", busy, 0);
        check_eq("f2_hold_start", start, 0);

        // Overflow frame with cross_complete still high from before
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int i = 0; i < 515; i++) put(i, i + 1, i, i >> 3);
        check_eq("ovf_sticky", overflow, 1);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check_eq("ovf_size", box_size, 511);
        check_eq("ovf_mask", box_flag_true, exp_mask);
        check_eq("ovf_busy", busy, 1);
        rd_addr = 9'd510; tick();
        check_eq("ovf_start", start, 1);
        check_eq("ovf_rd510", {rd_x0, rd_xn, rd_y0, rd_yn}, pk(510, 511, 510, 63));
        rd_addr = 9'd511; tick();
        check_eq("ovf_rd511", {rd_x0, rd_xn, rd_y0, rd_yn}, 0);
        repeat (3) tick();
        check_eq("ovf_leftover_cc", busy, 1);
        cross_complete = 1'b0; tick();
        cross_complete = 1'b1; tick();
        check_eq("ovf_done_busy", busy, 0);

        // Empty frame
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check_eq("empty_ovf_clear", overflow, 0);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check_eq("empty_pulse", empty_frame, 1);
        check_eq("empty_size", box_size, 0);
        check_eq("empty_mask", box_flag_true, 0);
        check_eq("empty_busy", busy, 0);
        tick();
        check_eq("empty_pulse_end", empty_frame, 0);
        check_eq("empty_no_start", start, 0);

        // Reset while busy with start still pending
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        put(1, 1, 1, 1);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check_eq("rst_pre_busy", busy, 1);
        rd_addr = 9'd0;
        reset = 1'b1; tick();
        check_all_zero("rst_mid");
        reset = 1'b0; tick();
        check_eq("rst_no_start", start, 0);
        check_eq("rst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
